// File: rtl/ysyx_22050039_mem_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM state and owner
// encodings, grant-vector bit positions and the byte-mask width derivation.
// The optional macro YSYX_22050039_MEM_ARB_RR_EN selects round-robin
// arbitration in the picker. Without it, the LSU has fixed priority.
package ysyx_22050039_mem_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  // Bit positions inside the two-bit request and grant vectors.
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  // Number of byte-enable bits for a given data width.
  function automatic int mask_w_of(input int xlen);
    return xlen / 8;
  endfunction

  // Map a one-hot grant vector onto the owner encoding.
  function automatic owner_e gnt_owner(input logic [1:0] gnt);
    owner_e o;
    if (gnt[GNT_LSU] == 1'b1) begin
      o = OWNER_LSU;
    end else begin
      o = OWNER_IFU;
    end
    return o;
  endfunction

endpackage

// File: rtl/ysyx_22050039_mem_arb_pick.sv
// Two-input grant logic for the memory arbiter.
// Default: the LSU always wins a tie against the IFU.
// With YSYX_22050039_MEM_ARB_RR_EN defined, a last_grant register makes the
// requester that was not granted last win a tie. last_grant is updated only
// when the arbiter actually accepts a request (adv).
module ysyx_22050039_mem_arb_pick
  import ysyx_22050039_mem_pkg::*;
(
`ifdef YSYX_22050039_MEM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef YSYX_22050039_MEM_ARB_RR_EN
  owner_e last_grant_r;

  // Remember which requester was granted most recently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_r <= OWNER_IFU;
    end else if (adv) begin
      last_grant_r <= gnt_owner(gnt);
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Round-robin pick: on a tie, grant the side not granted last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (last_grant_r == OWNER_IFU) begin
          gnt = 2'b10;
        end else begin
          gnt = 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
  end
`else
  // Fixed-priority pick: the LSU wins a tie, the IFU waits.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/ysyx_22050039_mem_arb.sv
// Shared memory-port arbiter between instruction fetch (IFU) and load/store
// (LSU) requesters. Only one transaction is outstanding at a time.
//   IDLE: grant one requester (its ready is combinational) and latch its fields.
//   REQ : present the latched request until the memory handshakes.
//   WAIT: capture the response into the owner's rdata. The owner's
//         rsp_valid pulses on the following cycle, already back in IDLE.
// Reset (rst low, synchronous) drops any transaction in flight and clears
// every output, including the held rdata registers.
// YSYX_22050039_MEM_ARB_RR_EN selects round-robin arbitration.
// Without it, the LSU has fixed priority over the IFU.
module ysyx_22050039_mem_arb
  import ysyx_22050039_mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int MASK_W = mask_w_of(XLEN)
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch requester
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [XLEN-1:0]   ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [XLEN-1:0]   ifu_rdata,
  // load/store requester
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic              lsu_wen,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [XLEN-1:0]   lsu_rdata,
  // memory bridge
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  // status
  output logic              busy
);

  state_e            state_r;
  owner_e            owner_r;
  logic              busy_r;
  logic              mem_req_valid_r;
  logic [XLEN-1:0]   mem_addr_r;
  logic              mem_wen_r;
  logic [XLEN-1:0]   mem_wdata_r;
  logic [MASK_W-1:0] mem_wmask_r;
  logic              ifu_rsp_valid_r;
  logic [XLEN-1:0]   ifu_rdata_r;
  logic              lsu_rsp_valid_r;
  logic [XLEN-1:0]   lsu_rdata_r;

  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  logic              grant_s;

  assign req_s = {lsu_req_valid, ifu_req_valid};

  ysyx_22050039_mem_arb_pick u_pick (
`ifdef YSYX_22050039_MEM_ARB_RR_EN
    .clk (clk),
    .rst (rst),
    .adv (grant_s),
`endif
    .req (req_s),
    .gnt (gnt_s)
  );

  // A grant is taken only from IDLE and never while reset is held.
  assign grant_s       = rst && (state_r == IDLE) && (gnt_s != 2'b00);
  assign ifu_req_ready = grant_s && gnt_s[GNT_IFU];
  assign lsu_req_ready = grant_s && gnt_s[GNT_LSU];

  assign busy          = busy_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wen       = mem_wen_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_wmask     = mem_wmask_r;
  assign ifu_rsp_valid = ifu_rsp_valid_r;
  assign ifu_rdata     = ifu_rdata_r;
  assign lsu_rsp_valid = lsu_rsp_valid_r;
  assign lsu_rdata     = lsu_rdata_r;

  // Arbiter FSM with registered memory request, response pulses and rdata.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r         <= IDLE;
      owner_r         <= OWNER_IFU;
      busy_r          <= 1'b0;
      mem_req_valid_r <= 1'b0;
      mem_addr_r      <= {XLEN{1'b0}};
      mem_wen_r       <= 1'b0;
      mem_wdata_r     <= {XLEN{1'b0}};
      mem_wmask_r     <= {MASK_W{1'b0}};
      ifu_rsp_valid_r <= 1'b0;
      ifu_rdata_r     <= {XLEN{1'b0}};
      lsu_rsp_valid_r <= 1'b0;
      lsu_rdata_r     <= {XLEN{1'b0}};
    end else begin
      // Response strobes last exactly one cycle.
      ifu_rsp_valid_r <= 1'b0;
      lsu_rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            owner_r         <= gnt_owner(gnt_s);
            mem_req_valid_r <= 1'b1;
            busy_r          <= 1'b1;
            state_r         <= REQ;
            if (gnt_s[GNT_LSU]) begin
              mem_addr_r  <= lsu_addr;
              mem_wen_r   <= lsu_wen;
              mem_wdata_r <= lsu_wdata;
              mem_wmask_r <= lsu_wmask;
            end else begin
              // Fetches are always plain reads.
              mem_addr_r  <= ifu_addr;
              mem_wen_r   <= 1'b0;
              mem_wdata_r <= {XLEN{1'b0}};
              mem_wmask_r <= {MASK_W{1'b0}};
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          // Fields stay frozen until the bridge takes the request.
          // A response arriving here is spurious and ignored.
          if (mem_req_valid_r && mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            state_r         <= WAIT;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            // Store acks also forward mem_rdata.
            if (owner_r == OWNER_LSU) begin
              lsu_rdata_r     <= mem_rdata;
              lsu_rsp_valid_r <= 1'b1;
            end else begin
              ifu_rdata_r     <= mem_rdata;
              ifu_rsp_valid_r <= 1'b1;
            end
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          mem_req_valid_r <= 1'b0;
          busy_r          <= 1'b0;
          state_r         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_mem_arb.sv
// Self-checking bench for ysyx_22050039_mem_arb.
// The bench uses table-driven single transactions plus hand-written
// sequences for contention, spurious responses and reset mid-transaction.
module tb_ysyx_22050039_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ysyx_22050039_mem_arb #(.XLEN(64), .MASK_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifu_v;
    logic [63:0] ifu_a;
    logic        lsu_v;
    logic [63:0] lsu_a;
    logic        wen;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic [63:0] rd;
    int          stall;
    logic        exp_lsu;
    logic [63:0] exp_a;
    logic        exp_wen;
    logic [63:0] exp_wd;
    logic [7:0]  exp_wm;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_addr = 64'h0;
    lsu_req_valid = 1'b0; lsu_addr = 64'h0; lsu_wen = 1'b0;
    lsu_wdata = 64'h0; lsu_wmask = 8'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
  endtask

  // Called at a negedge while the DUT is in REQ. The task completes the
  // transaction and ends at the negedge of the response-pulse cycle.
  task automatic finish_txn(input string nm, input logic exp_lsu, input logic [63:0] rd);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk({nm, "_wait_reqv"}, {63'h0, mem_req_valid}, 64'h0);
    chk({nm, "_wait_busy"}, {63'h0, busy}, 64'h1);
    mem_rsp_valid = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rdata = 64'h0;
    #1;
    chk({nm, "_rsp_pair"}, {62'h0, lsu_rsp_valid, ifu_rsp_valid},
        exp_lsu ? 64'h2 : 64'h1);
    chk({nm, "_rdata"}, exp_lsu ? lsu_rdata : ifu_rdata, rd);
    chk({nm, "_busy_done"}, {63'h0, busy}, 64'h0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string nm;
    nm = $sformatf("v%0d", i);
    @(negedge clk);
    ifu_req_valid = v.ifu_v; ifu_addr = v.ifu_a;
    lsu_req_valid = v.lsu_v; lsu_addr = v.lsu_a; lsu_wen = v.wen;
    lsu_wdata = v.wd; lsu_wmask = v.wm;
    #1;
    chk({nm, "_ready"}, {62'h0, lsu_req_ready, ifu_req_ready},
        v.exp_lsu ? 64'h2 : 64'h1);
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    lsu_wdata = 64'hA5A5_A5A5_A5A5_A5A5; lsu_addr = 64'h1;
    #1;
    chk({nm, "_reqv"}, {62'h0, busy, mem_req_valid}, 64'h3);
    chk({nm, "_addr"}, mem_addr, v.exp_a);
    chk({nm, "_wen"}, {63'h0, mem_wen}, {63'h0, v.exp_wen});
    chk({nm, "_wdata"}, mem_wdata, v.exp_wd);
    chk({nm, "_wmask"}, {56'h0, mem_wmask}, {56'h0, v.exp_wm});
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      #1;
      chk($sformatf("%s_stall%0d", nm, s),
          {mem_req_valid, mem_wen, mem_wmask, mem_addr[53:0] ^ mem_wdata[53:0]},
          {1'b1, v.exp_wen, v.exp_wm, v.exp_a[53:0] ^ v.exp_wd[53:0]});
    end
    finish_txn(nm, v.exp_lsu, v.exp_rd);
    @(negedge clk);
    #1;
    chk({nm, "_pulse_end"}, {62'h0, lsu_rsp_valid, ifu_rsp_valid}, 64'h0);
  endtask

  logic exp_order[4];
  logic [63:0] last_ifu_rd;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00,
                64'h0000_0000_0010_0073, 0,
                1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h0000_0000_0010_0073};
    vecs[1] = '{1'b0, 64'h0, 1'b1, 64'h8000_2000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F,
                64'h0000_0000_DEAD_BEEF, 5,
                1'b1, 64'h8000_2000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F,
                64'h0000_0000_DEAD_BEEF};
    vecs[2] = '{1'b0, 64'h0, 1'b1, 64'h8000_1000, 1'b0, 64'h0, 8'h00,
                64'hCAFE_F00D_1234_5678, 1,
                1'b1, 64'h8000_1000, 1'b0, 64'h0, 8'h00, 64'hCAFE_F00D_1234_5678};
    // IFU request while the LSU store fields are busy but not valid
    vecs[3] = '{1'b1, 64'h8000_0010, 1'b0, 64'h9000_0000, 1'b1, 64'hFFFF_0000_FFFF_0000, 8'hFF,
                64'h0000_0000_0000_0013, 0,
                1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, 64'h0000_0000_0000_0013};
    vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00,
                64'hFFFF_FFFF_FFFF_FFFF, 2,
                1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{1'b0, 64'h0, 1'b1, 64'h0, 1'b0, 64'h0, 8'hFF,
                64'h0123_4567_89AB_CDEF, 0,
                1'b1, 64'h0, 1'b0, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF};
`ifdef YSYX_22050039_MEM_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset, then idle.
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ctrl", {57'h0, busy, mem_req_valid, mem_wen, ifu_rsp_valid, lsu_rsp_valid,
                     ifu_req_ready, lsu_req_ready}, 64'h0);
    chk("rst_data", mem_addr | mem_wdata | ifu_rdata | lsu_rdata | {56'h0, mem_wmask}, 64'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle%0d", c), {62'h0, busy, mem_req_valid}, 64'h0);
    end

    // Table-driven single transactions.
    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
    end
    last_ifu_rd = vecs[4].exp_rd;

    // Spurious response while IDLE.
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = 64'h5555;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("spur_idle_pulse", {61'h0, busy, lsu_rsp_valid, ifu_rsp_valid}, 64'h0);
    chk("spur_idle_rdata", ifu_rdata, last_ifu_rd);

    // Spurious response while in REQ.
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0100;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 64'h6666;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("spur_req_state", {60'h0, busy, mem_req_valid, lsu_rsp_valid, ifu_rsp_valid}, 64'hC);
    chk("spur_req_rdata", ifu_rdata, last_ifu_rd);
    @(negedge clk);
    #1;
    chk("spur_req_nopulse", {62'h0, lsu_rsp_valid, ifu_rsp_valid}, 64'h0);
    finish_txn("spur_fin", 1'b0, 64'h0000_0000_0000_1234);

    // Reset while in WAIT.
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_3000; lsu_wen = 1'b0;
    @(negedge clk);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("rstw_in_wait", {62'h0, busy, mem_req_valid}, 64'h2);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rstw_ctrl", {60'h0, busy, mem_req_valid, lsu_rsp_valid, ifu_rsp_valid}, 64'h0);
    chk("rstw_data", mem_addr | ifu_rdata | lsu_rdata, 64'h0);
    rst = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 64'h7777;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("rstw_late_rsp", {61'h0, busy, lsu_rsp_valid, ifu_rsp_valid}, 64'h0);
    @(negedge clk);
    #1;
    chk("rstw_late_rsp2", {61'h0, busy, lsu_rsp_valid, ifu_rsp_valid}, 64'h0);
    chk("rstw_rdata", lsu_rdata, 64'h0);

    // Contention: LSU first, IFU stays pending until LSU completes.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_1000; lsu_wen = 1'b0;
    #1;
    chk("cont_grant1", {62'h0, lsu_req_ready, ifu_req_ready}, 64'h2);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    #1;
    chk("cont_ifu_wait_req", {63'h0, ifu_req_ready}, 64'h0);
    chk("cont_addr1", mem_addr, 64'h8000_1000);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("cont_ifu_wait_wait", {63'h0, ifu_req_ready}, 64'h0);
    mem_rsp_valid = 1'b1; mem_rdata = 64'h1111;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("cont_lsu_rsp", {62'h0, lsu_rsp_valid, ifu_rsp_valid}, 64'h2);
    chk("cont_grant2", {62'h0, lsu_req_ready, ifu_req_ready}, 64'h1);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    chk("cont_addr2", mem_addr, 64'h8000_0004);
    finish_txn("cont_ifu", 1'b0, 64'h2222);

    // Both held valid across four transactions.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0008;
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_1008;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("hold_grant%0d", k), {62'h0, lsu_req_ready, ifu_req_ready},
          exp_order[k] ? 64'h2 : 64'h1);
      @(negedge clk);
      #1;
      chk($sformatf("hold_addr%0d", k), mem_addr,
          exp_order[k] ? 64'h8000_1008 : 64'h8000_0008);
      finish_txn($sformatf("hold%0d", k), exp_order[k], 64'h4000 + 64'(k));
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("final_idle", {62'h0, busy, mem_req_valid}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
